// File: rtl/game_types_pkg.sv
// Shared types for the digit entry block.
// State encoding and LFSR feedback taps.
package game_types;

  typedef enum logic [1:0] {
    IDLE,
    ENTER,
    RAND,
    DONE
  } entry_state_t;

  // Fibonacci taps 8,6,5,4 as bit positions 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic lfsr_fb(input logic [7:0] s);
    return ^(s & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/digit_entry_debounce.sv
// Key synchronizer and debouncer.
// Emits one press pulse per stable low period.
module key_debounce #(
  parameter int unsigned CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int W = $clog2(CYCLES + 1);

  logic         s1;
  logic         s2;
  logic         held;
  logic [W-1:0] cnt;

  // Count while the synced level disagrees with the accepted level.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      held  <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= key_n;
      s2    <= s1;
      press <= 1'b0;
      if (s2 == held) begin
        if (cnt == W'(CYCLES - 1)) begin
          cnt   <= '0;
          held  <= ~held;
          press <= ~held;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/digit_entry.sv
// Four-digit distinct entry from one-hot switches,
// with debounced keys and LFSR random fill.
module digit_entry
  import game_types::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter logic [7:0]  LFSR_SEED       = 8'h5A
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            mode,
  input  logic [9:0]      SW,
  input  logic            key_confirm_n,
  input  logic            key_random_n,
  output logic [3:0]      candidate,
  output logic            sw_valid,
  output logic [3:0][3:0] digits,
  output logic [3:0]      is_random,
  output logic [1:0]      pos,
  output logic            busy,
  output logic            done
);

  entry_state_t    state;
  entry_state_t    state_n;
  logic [3:0][3:0] digits_n;
  logic [3:0]      is_random_n;
  logic [1:0]      pos_n;
  logic            mode_q;
  logic            mode_n;
  logic [7:0]      lfsr;
  logic            conf_ev;
  logic            rand_ev;
  logic [3:0]      ones;
  logic [3:0]      idx;
  logic            used;
  logic [3:0]      r;
  logic            r_dup;
  logic            r_ok;

  key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_conf (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_confirm_n),
    .press (conf_ev)
  );

  key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_rand (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_random_n),
    .press (rand_ev)
  );

  assign busy = (state == ENTER) || (state == RAND);
  assign done = (state == DONE);
  assign r    = lfsr[3:0];

  always_comb begin
    ones  = '0;
    idx   = '0;
    used  = 1'b0;
    r_dup = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (SW[i]) begin
        ones = ones + 4'd1;
        idx  = 4'(i);
      end
    end
    candidate = (ones == 4'd1) ? idx : 4'd0;
    // Only positions left of pos hold committed digits.
    for (int p = 0; p < 4; p++) begin
      if (p > int'(pos)) begin
        if (digits[p] == candidate) used = 1'b1;
        if (digits[p] == r) r_dup = 1'b1;
      end
    end
    sw_valid = busy && (ones == 4'd1) && !used;
    r_ok     = (r <= 4'd9) && !r_dup;
  end

  always_comb begin
    state_n     = state;
    digits_n    = digits;
    is_random_n = is_random;
    pos_n       = pos;
    mode_n      = mode_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          digits_n    = '0;
          is_random_n = '0;
          pos_n       = 2'd3;
          mode_n      = mode;
          state_n     = ENTER;
        end
      end
      ENTER: begin
        if (start) begin
          digits_n    = '0;
          is_random_n = '0;
          pos_n       = 2'd3;
          mode_n      = mode;
        end else if (conf_ev) begin
          if (sw_valid) begin
            digits_n[pos]    = candidate;
            is_random_n[pos] = 1'b0;
            if (pos != 2'd0) pos_n = pos - 2'd1;
            else             state_n = DONE;
          end
        end else if (rand_ev && !mode_q) begin
          state_n = RAND;
        end
      end
      RAND: begin
        if (start) begin
          digits_n    = '0;
          is_random_n = '0;
          pos_n       = 2'd3;
          mode_n      = mode;
          state_n     = ENTER;
        end else if (r_ok) begin
          digits_n[pos]    = r;
          is_random_n[pos] = 1'b1;
          if (pos != 2'd0) begin
            pos_n   = pos - 2'd1;
            state_n = ENTER;
          end else begin
            state_n = DONE;
          end
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      digits    <= '0;
      is_random <= '0;
      pos       <= 2'd3;
      mode_q    <= 1'b0;
      lfsr      <= LFSR_SEED;
    end else begin
      state     <= state_n;
      digits    <= digits_n;
      is_random <= is_random_n;
      pos       <= pos_n;
      mode_q    <= mode_n;
      lfsr      <= {lfsr[6:0], lfsr_fb(lfsr)};
    end
  end

endmodule

// File: tb/tb_digit_entry.sv
// Randomized self-checking bench for digit_entry
// against a behavioural entry model.
module tb_digit_entry;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            mode = 1'b0;
  logic [9:0]      SW = '0;
  logic            key_confirm_n = 1'b1;
  logic            key_random_n = 1'b1;
  logic [3:0]      candidate;
  logic            sw_valid;
  logic [3:0][3:0] digits;
  logic [3:0]      is_random;
  logic [1:0]      pos;
  logic            busy;
  logic            done;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  int m_d[4];
  int m_r[4];
  int m_pos;
  int m_busy;
  int m_mode;
  int m_done;

  always #5 clk = ~clk;

  digit_entry #(.DEBOUNCE_CYCLES(4), .LFSR_SEED(8'h5A)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .mode          (mode),
    .SW            (SW),
    .key_confirm_n (key_confirm_n),
    .key_random_n  (key_random_n),
    .candidate     (candidate),
    .sw_valid      (sw_valid),
    .digits        (digits),
    .is_random     (is_random),
    .pos           (pos),
    .busy          (busy),
    .done          (done)
  );

  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int m_cand(input logic [9:0] s);
    if ($countones(s) != 1) return 0;
    for (int i = 0; i < 10; i++) if (s[i]) return i;
    return 0;
  endfunction

  function automatic int m_valid(input logic [9:0] s);
    int c;
    if (m_busy == 0 || $countones(s) != 1) return 0;
    c = m_cand(s);
    for (int p = m_pos + 1; p < 4; p++) if (m_d[p] == c) return 0;
    return 1;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 4; i++) begin
      m_d[i] = 0;
      m_r[i] = 0;
    end
    m_pos  = 3;
    m_busy = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_pos"}, pos, m_pos);
    chk({tag, "_busy"}, busy, m_busy);
    chk({tag, "_done"}, done_cnt, m_done);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_dig"}, digits[i], m_d[i]);
      chk({tag, "_rnd"}, is_random[i], m_r[i]);
    end
  endtask

  task automatic do_start(input int md);
    tick();
    start = 1'b1;
    mode  = md[0];
    tick();
    start = 1'b0;
    m_clear();
    m_busy = 1;
    m_mode = md;
  endtask

  task automatic press(input bit c, input bit r);
    tick();
    key_confirm_n = ~c;
    key_random_n  = ~r;
    repeat (10) tick();
    key_confirm_n = 1'b1;
    key_random_n  = 1'b1;
    repeat (10) tick();
  endtask

  // Drive SW, check combinational outputs, press keys, update model.
  task automatic step(input logic [9:0] s, input bit c, input bit r,
                      input string tag);
    int v;
    int cd;
    tick();
    SW = s;
    #1;
    cd = m_cand(s);
    v  = m_valid(s);
    chk({tag, "_cand"}, candidate, cd);
    chk({tag, "_valid"}, sw_valid, v);
    press(c, r);
    if (c && v == 1) begin
      m_d[m_pos] = cd;
      m_r[m_pos] = 0;
      if (m_pos == 0) begin
        m_busy = 0;
        m_done++;
      end else begin
        m_pos--;
      end
    end
    chk({tag, "_pos"}, pos, m_pos);
    chk({tag, "_busy"}, busy, m_busy);
  endtask

  task automatic rand_fill(input string tag);
    int old;
    int k;
    old = m_pos;
    press(1'b0, 1'b1);
    k = 0;
    while (pos == 2'(old) && busy && k < 300) begin
      tick();
      k++;
    end
    chk({tag, "_timeout"}, (k < 300) ? 1 : 0, 1);
    repeat (3) tick();
    chk({tag, "_le9"}, (digits[old] <= 4'd9) ? 1 : 0, 1);
    chk({tag, "_flag"}, is_random[old], 1);
    if (old == 0) begin
      m_busy = 0;
      m_done++;
    end else begin
      m_pos--;
    end
    chk({tag, "_pos"}, pos, m_pos);
  endtask

  initial begin
    int ok;
    int att;
    logic [9:0] s;
    m_clear();
    m_mode = 1;
    m_done = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_state("reset");
    chk("reset_valid", sw_valid, 0);

    // Directed guess entry 5,1,9,0 with duplicate and non-one-hot probes.
    do_start(1);
    step(10'b1 << 5, 1, 0, "g5");
    step(10'b1 << 5, 1, 0, "dup5");
    step(10'b0000000011, 1, 0, "two_hot");
    step(10'b1 << 1, 1, 0, "g1");
    step(10'b1 << 9, 1, 0, "g9");
    step(10'b1 << 0, 1, 0, "g0");
    check_state("guess_end");

    // Bouncing key followed by a clean hold commits exactly once.
    do_start(1);
    tick();
    SW = 10'b1 << 4;
    for (int i = 0; i < 5; i++) begin
      key_confirm_n = 1'b0;
      repeat (2) tick();
      key_confirm_n = 1'b1;
      repeat (2) tick();
    end
    chk("bounce_pos", pos, 3);
    key_confirm_n = 1'b0;
    repeat (10) tick();
    key_confirm_n = 1'b1;
    repeat (10) tick();
    m_d[3] = 4;
    m_pos  = 2;
    check_state("bounce");

    // Random fill in set mode.
    do_start(0);
    for (int i = 0; i < 4; i++) rand_fill("rfill");
    ok = 1;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (digits[i] == digits[j]) ok = 0;
    chk("rand_distinct", ok, 1);
    chk("rand_flags", is_random, 4'hF);
    chk("rand_done", done_cnt, m_done);
    chk("rand_busy", busy, 0);

    // Random key ignored in guess mode.
    do_start(1);
    for (int i = 0; i < 4; i++) step(10'b1 << 2, 0, 1, "rand_m1");
    check_state("rand_m1_end");

    // Confirm and random together: confirm wins.
    do_start(0);
    step(10'b1 << 7, 1, 1, "both");
    repeat (20) tick();
    check_state("both_end");

    // Reset mid-entry at pos 1.
    do_start(1);
    step(10'b1 << 3, 1, 0, "pre");
    step(10'b1 << 8, 1, 0, "pre");
    tick();
    SW  = '0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    m_clear();
    check_state("rst_mid");
    chk("rst_cand", candidate, 0);
    chk("rst_valid", sw_valid, 0);

    // Randomized guess sessions against the model.
    for (int e = 0; e < 4; e++) begin
      do_start(1);
      att = 0;
      while (m_busy == 1 && att < 40) begin
        if ($urandom_range(0, 3) == 0) s = 10'($urandom_range(0, 1023));
        else s = 10'b1 << $urandom_range(0, 9);
        step(s, $urandom_range(0, 5) != 0, $urandom_range(0, 3) == 0,
             "rnd");
        att++;
      end
      check_state("rnd_end");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/digit_entry.md
DIGIT_ENTRY -- requirements
Module: digit_entry

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, is the number of stable raw-key cycles required to accept a press (20 ms at 50 MHz).
REQ-002 Parameter LFSR_SEED, default 8'h5A, is the nonzero LFSR reset value.
REQ-003 clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  one-cycle pulse that begins a new 4-digit entry.
REQ-006 mode  input  1  sampled on start: 0 = set target (random fill allowed), 1 = guess (random fill disabled).
REQ-007 SW  input  10  raw slide switches; a one-hot setting selects digit 0-9.
REQ-008 key_confirm_n  input  1  raw confirm push-button, active-low, asynchronous to clk.
REQ-009 key_random_n  input  1  raw random-fill push-button, active-low, asynchronous to clk.
REQ-010 candidate  output  4  index of the single high SW bit; 0 when SW is not one-hot.
REQ-011 sw_valid  output  1  SW is one-hot and candidate is unused in already-entered positions.
REQ-012 digits  output  4x4  entered digits, digits[3] is leftmost.
REQ-013 is_random  output  4  per-position flag: digit was LFSR-filled.
REQ-014 pos  output  2  position currently being entered (3 down to 0).
REQ-015 busy  output  1  high while an entry is in progress.
REQ-016 done  output  1  one-cycle pulse when position 0 is committed.

Function
REQ-017 Each key is passed through a 2-FF synchronizer, then a debounce counter; a press event is exactly one cycle, issued when the synchronized level has been low for DEBOUNCE_CYCLES consecutive cycles, and no further event until the key has been stably high for DEBOUNCE_CYCLES.
REQ-018 candidate and sw_valid are combinational from SW, digits, pos and busy; sw_valid is 0 when busy is 0.
REQ-019 FSM states IDLE, ENTER, RAND, DONE; encoding lives in game_types.
REQ-020 IDLE: on start, clear digits and is_random to 0, set pos=3, latch mode, go to ENTER; busy=1 from the next cycle.
REQ-021 ENTER: a confirm event with sw_valid=1 writes candidate into digits[pos] and clears is_random[pos]; a confirm event with sw_valid=0 is ignored.
REQ-022 ENTER: a random event in mode 0 goes to RAND; in mode 1 it is ignored.
REQ-023 A confirm event and a random event in the same cycle: confirm wins and the random event is discarded.
REQ-024 RAND: each cycle, lfsr[3:0] is accepted if it is at most 9 and differs from digits[3:pos+1]; on acceptance write it to digits[pos], set is_random[pos], commit; otherwise retry next cycle. Worst-case retry is bounded by the LFSR period of 255.
REQ-025 LFSR: 8-bit maximal-length Fibonacci (taps 8,6,5,4), free-running every cycle including IDLE.
REQ-026 Commit: if pos>0, decrement pos and return to ENTER; if pos=0, go to DONE.
REQ-027 DONE: assert done for exactly one cycle, deassert busy, and go to IDLE; digits and is_random hold until the next start.
REQ-028 A start pulse in ENTER or RAND aborts and restarts as in REQ-020; key events in IDLE or DONE are ignored.
REQ-029 All four committed digits are pairwise distinct.

Reset
REQ-030 On rst: state=IDLE, digits all 0, is_random=0, pos=3, busy=0, done=0, lfsr=LFSR_SEED, debounce counters 0, and key trackers treat the keys as released.
REQ-031 rst asserted mid-entry discards the partial entry; no done pulse is emitted.

Structure
REQ-032 entry_state_t and the LFSR tap constant belong in package game_types.
REQ-033 Debounce is one sub-module, key_debounce (sync, counter, event pulse), instantiated twice.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-034 start with mode=1; SW one-hot 5,1,9,0, each followed by a confirm press -> digits=5,1,9,0, is_random=0000, done pulses once, busy falls.
REQ-035 After digit 5 is committed, SW=5 -> sw_valid=0; a confirm press leaves pos=2. SW=10'b0000000011 -> sw_valid=0, candidate=0.
REQ-036 Key bouncing low/high every 2 cycles for 20 cycles, then held low for 10 cycles -> exactly one commit.
REQ-037 mode=0 with random pressed 4 times -> is_random=1111, four distinct digits each at most 9, done pulses; same sequence in mode=1 -> pos stays 3.
REQ-038 Confirm and random events in the same cycle with SW=7 -> digits[3]=7, is_random[3]=0; rst at pos=1 -> all outputs return to reset values and no done pulse.
